// File: rtl/uart_string_rx_pkg.sv
// uart_string_rx_pkg: delimiter, default capacity and state
// encodings shared by the framed-string receiver and its byte UART.
package uart_string_rx_pkg;

  localparam logic [7:0] UART_STR_DELIM  = 8'h26;
  localparam int         DEFAULT_MAX_LEN = 137;

  // One-hot frame states; B_* are the bit positions.
  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_SOF1    = 4'b0010,
    S_CONTENT = 4'b0100,
    S_EOF1    = 4'b1000
  } str_state_e;

  localparam int B_IDLE    = 0;
  localparam int B_SOF1    = 1;
  localparam int B_CONTENT = 2;
  localparam int B_EOF1    = 3;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_string_rx_uart_rx.sv
// uart_string_rx_uart_rx: 8N1 byte receiver, LSB first.
// Ports: clk, rst_n (sync, low), rx line in; rx_data/rx_vld 1-cycle byte out.
module uart_string_rx_uart_rx
  import uart_string_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_vld
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (CPB > 4) ? $clog2(CPB) : 2;
  localparam logic [CW-1:0] T_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] T_HALF = CW'(CPB / 2 - 1);

  rx_state_e     st_q, st_d;
  logic          rx_s1_q, rx_s2_q;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= R_IDLE;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  // Start bit is re-checked at mid-bit to reject glitches.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      R_IDLE:  if (!rx_s2_q) st_d = R_START;
      R_START: if (tick_q == T_HALF)
                 st_d = rx_s2_q ? R_IDLE : R_DATA;
      R_DATA:  if (tick_q == T_FULL && bit_q == 3'd7)
                 st_d = R_STOP;
      R_STOP:  if (tick_q == T_FULL) st_d = R_IDLE;
      default: st_d = R_IDLE;
    endcase
  end

  always_comb begin
    tick_d = tick_q + 1'b1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    data_d = data_q;
    vld_d  = 1'b0;
    unique case (st_q)
      R_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
      end
      R_START: if (tick_q == T_HALF) tick_d = '0;
      R_DATA: if (tick_q == T_FULL) begin
        tick_d = '0;
        sh_d   = {rx_s2_q, sh_q[7:1]};
        bit_d  = bit_q + 3'd1;
      end
      // A byte with a broken stop bit is dropped.
      R_STOP: if (tick_q == T_FULL) begin
        tick_d = '0;
        vld_d  = rx_s2_q;
        data_d = sh_q;
      end
      default: tick_d = '0;
    endcase
  end

  assign rx_data = data_q;
  assign rx_vld  = vld_q;

endmodule

// File: rtl/uart_string_rx.sv
// uart_string_rx: receives &&payload&& frames, strips delimiters, buffers payload.
// Ports: sys_clk, sys_rst_n (sync, low), uart_rx_port; rx_string/rx_length,
// rx_busy, rx_done/rx_err pulses. `UART_STRING_RX_TIMEOUT_EN adds inter-byte timeout.
module uart_string_rx
  import uart_string_rx_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int TIMEOUT_CLK = 500_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rx_port,
  output logic [8*MAX_LEN-1:0] rx_string,
  output logic [7:0]           rx_length,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 rx_err
);

  localparam logic [7:0] MAX_L = 8'(MAX_LEN);

  logic [7:0] rx_data;
  logic       rx_vld;

  uart_string_rx_uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_rx (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .rx     (uart_rx_port),
    .rx_data(rx_data),
    .rx_vld (rx_vld)
  );

  str_state_e           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [8*MAX_LEN-1:0] str_q, str_d;
  logic [7:0]           len_q, len_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic       is_delim, ovf_c, ovf_e, tmo;
  logic [7:0] cnt_p1;
  logic [8:0] cnt_p2;

  assign is_delim = (rx_data == UART_STR_DELIM);
  assign cnt_p1   = cnt_q + 8'd1;
  assign cnt_p2   = {1'b0, cnt_q} + 9'd2;
  assign ovf_c    = state_q[B_CONTENT] && !is_delim
                    && (cnt_q == MAX_L);
  // A lone & plus the following byte need two free slots.
  assign ovf_e    = state_q[B_EOF1] && !is_delim
                    && (cnt_p2 > {1'b0, MAX_L});

`ifdef UART_STRING_RX_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CLK + 1);
  localparam logic [GW-1:0] GAP_END = GW'(TIMEOUT_CLK);

  logic [GW-1:0] gap_q, gap_d, gap_inc;

  // A byte in the terminal cycle wins: it reloads the counter.
  always_comb begin
    gap_inc = gap_q + 1'b1;
    tmo     = !rx_vld && !state_q[B_IDLE]
              && (gap_inc == GAP_END);
    gap_d   = (rx_vld || state_q[B_IDLE] || tmo)
              ? '0 : gap_inc;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) gap_q <= '0;
    else            gap_q <= gap_d;
  end
`else
  // Timeout compiled out; a frame stays open until EOF or overflow.
  assign tmo = (TIMEOUT_CLK < 0);
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      str_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      str_q   <= str_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_vld) begin
      unique case (1'b1)
        state_q[B_IDLE]:
          if (is_delim) state_d = S_SOF1;
        state_q[B_SOF1]:
          state_d = is_delim ? S_CONTENT : S_IDLE;
        state_q[B_CONTENT]:
          if (is_delim)   state_d = S_EOF1;
          else if (ovf_c) state_d = S_IDLE;
        state_q[B_EOF1]:
          state_d = (is_delim || ovf_e) ? S_IDLE : S_CONTENT;
        default: state_d = S_IDLE;
      endcase
    end else if (tmo) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    str_d  = str_q;
    len_d  = len_q;
    done_d = 1'b0;
    err_d  = tmo;
    if (rx_vld) begin
      unique case (1'b1)
        state_q[B_SOF1]: if (is_delim) begin
          cnt_d = '0;
          str_d = '0;
        end
        state_q[B_CONTENT]: if (ovf_c) begin
          err_d = 1'b1;
        end else if (!is_delim) begin
          str_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_p1;
        end
        state_q[B_EOF1]: if (is_delim) begin
          len_d  = cnt_q;
          done_d = 1'b1;
        end else if (ovf_e) begin
          err_d = 1'b1;
        end else begin
          str_d[{cnt_q, 3'b000} +: 8]  = UART_STR_DELIM;
          str_d[{cnt_p1, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_p2[7:0];
        end
        default: ;
      endcase
    end
  end

  assign rx_string = str_q;
  assign rx_length = len_q;
  assign rx_busy   = !state_q[B_IDLE];
  assign rx_done   = done_q;
  assign rx_err    = err_q;

endmodule

// File: tb/tb_uart_string_rx.sv
// tb_uart_string_rx: directed frames over the serial line with a
// queue-based frame model checked every cycle, plus literal spot checks.
module tb_uart_string_rx;

  localparam int BAUD = 115_200;
  localparam int CPB  = 8;
  localparam int CLKF = BAUD * CPB;
  localparam int MAXL = 137;
  localparam int TMO  = 1000;
  localparam byte unsigned AMP = 8'h26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;
  logic [8*MAXL-1:0] rx_string;
  logic [7:0] rx_length;
  logic rx_busy, rx_done, rx_err;

  always #5 clk = ~clk;

  uart_string_rx #(
    .CLK_FREQ   (CLKF),
    .BAUD_RATE  (BAUD),
    .MAX_LEN    (MAXL),
    .TIMEOUT_CLK(TMO)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .uart_rx_port(line),
    .rx_string   (rx_string),
    .rx_length   (rx_length),
    .rx_busy     (rx_busy),
    .rx_done     (rx_done),
    .rx_err      (rx_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_shown = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else if (n_shown < 40) begin
      n_shown++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Frame model: bytes sent, payload of the open frame, last result.
  byte unsigned tx_q[$];
  byte unsigned pay[$];
  byte unsigned e_str[$];
  bit hdr, open, pend, armed;
  bit e_done, e_err, e_busy;
  int e_len;
  longint edge_k = 0;
  longint last_vld = 0;
  int dut_done_n = 0;
  int dut_err_n = 0;
  logic [8*MAXL-1:0] exp_s;

  function automatic void m_abort();
    hdr = 0;
    open = 0;
    pend = 0;
    e_err = 1;
  endfunction

  function automatic void m_byte(input byte unsigned b);
    if (open) begin
      if (!pend) begin
        if (b == AMP) pend = 1;
        else if (pay.size() >= MAXL) m_abort();
        else pay.push_back(b);
      end else if (b == AMP) begin
        e_str = pay;
        e_len = pay.size();
        e_done = 1;
        open = 0;
        pend = 0;
      end else if (pay.size() + 2 > MAXL) begin
        m_abort();
      end else begin
        pay.push_back(AMP);
        pay.push_back(b);
        pend = 0;
      end
    end else if (hdr) begin
      hdr = 0;
      if (b == AMP) begin
        open = 1;
        pend = 0;
        pay.delete();
      end
    end else if (b == AMP) begin
      hdr = 1;
    end
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("rx_done", rx_done, e_done);
      chk("rx_err", rx_err, e_err);
      chk("rx_busy", rx_busy, e_busy);
      chk("rx_length", rx_length, 64'(e_len));
      if (e_done) begin
        exp_s = '0;
        foreach (e_str[i]) exp_s[8*i +: 8] = e_str[i];
        n_chk++;
        if (rx_string === exp_s) n_pass++;
        else $display("FAIL rx_string: got low %0h expected low %0h",
                      rx_string[63:0], exp_s[63:0]);
      end
      if (rx_done) dut_done_n++;
      if (rx_err) dut_err_n++;
    end
    edge_k++;
    e_done = 0;
    e_err = 0;
    if (!rst_n) begin
      hdr = 0;
      open = 0;
      pend = 0;
      e_len = 0;
      e_busy = 0;
      tx_q.delete();
      armed = 1;
    end else if (armed) begin
      if (dut.rx_vld) begin
        if (tx_q.size() == 0) begin
          n_chk++;
          $display("FAIL byte_source: got a byte, expected none");
        end else begin
          m_byte(tx_q.pop_front());
        end
        last_vld = edge_k;
      end
`ifdef UART_STRING_RX_TIMEOUT_EN
      else if ((hdr || open) && (edge_k - last_vld == TMO)) begin
        m_abort();
      end
`endif
      e_busy = hdr || open;
    end
  end

  task automatic send_byte(input byte unsigned b);
    tx_q.push_back(b);
    @(negedge clk);
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    line = 1'b1;
    repeat (CPB + 2) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  int d0, e0;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    settle(5);
    chk("rst_length", rx_length, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_string_zero", 64'(rx_string == '0), 1);

    d0 = dut_done_n; e0 = dut_err_n;
    send_str("&&AB&&");
    settle(5);
    chk("t1_done_cnt", 64'(dut_done_n - d0), 1);
    chk("t1_err_cnt", 64'(dut_err_n - e0), 0);
    chk("t1_len", rx_length, 2);
    chk("t1_str", rx_string[15:0], 16'h4241);

    send_str("&&A&B&&");
    settle(5);
    chk("t2_len", rx_length, 3);
    chk("t2_str", rx_string[23:0], 24'h422641);

    d0 = dut_done_n;
    send_str("&&&&");
    settle(5);
    chk("t2_empty_done", 64'(dut_done_n - d0), 1);
    chk("t2_empty_len", rx_length, 0);

    d0 = dut_done_n; e0 = dut_err_n;
    send_str("X&Y");
    settle(5);
    chk("t3_noise_done", 64'(dut_done_n - d0), 0);
    chk("t3_noise_busy", rx_busy, 0);
    send_str("&&Z&&");
    settle(5);
    chk("t3_done_cnt", 64'(dut_done_n - d0), 1);
    chk("t3_len", rx_length, 1);
    chk("t3_str", rx_string[7:0], 8'h5A);
    chk("t3_err_cnt", 64'(dut_err_n - e0), 0);

    d0 = dut_done_n; e0 = dut_err_n;
    send_str("&&");
    for (int i = 0; i < 138; i++) send_byte(8'h55);
    settle(5);
    chk("t4_err_cnt", 64'(dut_err_n - e0), 1);
    chk("t4_done_cnt", 64'(dut_done_n - d0), 0);
    chk("t4_busy", rx_busy, 0);
    send_str("&&1&&");
    settle(5);
    chk("t4_next_len", rx_length, 1);
    chk("t4_next_str", rx_string[7:0], 8'h31);

    e0 = dut_err_n;
    send_str("&&AB");
    settle(1200);
`ifdef UART_STRING_RX_TIMEOUT_EN
    chk("t5_err_cnt", 64'(dut_err_n - e0), 1);
    chk("t5_busy", rx_busy, 0);
`else
    chk("t5_err_cnt", 64'(dut_err_n - e0), 0);
    chk("t5_busy", rx_busy, 1);
`endif
    pulse_reset();
    settle(3);

    d0 = dut_done_n; e0 = dut_err_n;
    send_str("&&A");
    settle(3);
    chk("t6_busy_before", rx_busy, 1);
    pulse_reset();
    @(negedge clk);
    chk("t6_length", rx_length, 0);
    chk("t6_busy", rx_busy, 0);
    chk("t6_string_zero", 64'(rx_string == '0), 1);
    settle(3);
    chk("t6_err_cnt", 64'(dut_err_n - e0), 0);
    send_str("&&B&&");
    settle(5);
    chk("t6_done_cnt", 64'(dut_done_n - d0), 1);
    chk("t6_len", rx_length, 1);
    chk("t6_str", rx_string[7:0], 8'h42);

    settle(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
